// File: rtl/sa_pkg.sv
// Shared constants and types for the systolic-array result path.
// Default geometry values are used as parameter defaults by the blocks that import this package.
package sa_pkg;

   localparam int SA_N      = 32;
   localparam int SA_ACC_W  = 32;
   localparam int SA_OUT_W  = 8;
   localparam int SA_PACK   = 4;
   localparam int SA_ADDR_W = 10;

   localparam int SHIFT_W   = 5;
   localparam int SAT_CNT_W = 16;

   typedef enum logic [1:0] {
      WB_IDLE  = 2'd0,
      WB_DRAIN = 2'd1,
      WB_DONE  = 2'd2
   } wb_state_e;

   // Index width that stays legal when only a single entry exists.
   function automatic int clog2_min1(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/requant_sat.sv
// One-element requantiser: round-half-up arithmetic right shift, then clamp to the signed
// OUT_W range. Purely combinational; sat_o flags an element that had to be clamped.
module requant_sat
   import sa_pkg::*;
#(
   parameter int ACC_W = SA_ACC_W,
   parameter int OUT_W = SA_OUT_W
) (
   input  logic [ACC_W-1:0]   acc_i,
   input  logic [SHIFT_W-1:0] shift_i,
   output logic [OUT_W-1:0]   q_o,
   output logic               sat_o
);

   localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'(2**(OUT_W-1) - 1);
   localparam logic signed [ACC_W:0] MIN_V = (ACC_W+1)'(-(2**(OUT_W-1)));

   logic [SHIFT_W-1:0]    shift_eff;
   logic signed [ACC_W:0] acc_ext;
   logic signed [ACC_W:0] round_v;
   logic signed [ACC_W:0] sum_v;
   logic signed [ACC_W:0] shifted_v;

   // NOTE: combinational blocks use blocking assignments and give every output a
   // default first, so later lines see earlier results and no latch is inferred.
   always_comb begin
      shift_eff = shift_i;
      if (int'(shift_i) >= ACC_W) begin
         shift_eff = SHIFT_W'(ACC_W - 1);
      end

      // One guard bit keeps the rounding add from overflowing.
      acc_ext   = {acc_i[ACC_W-1], acc_i};
      round_v   = (shift_eff == '0) ? '0 : ((ACC_W+1)'(1) << (shift_eff - SHIFT_W'(1)));
      sum_v     = acc_ext + round_v;
      shifted_v = sum_v >>> shift_eff;

      q_o   = shifted_v[OUT_W-1:0];
      sat_o = 1'b0;
      if (shifted_v > MAX_V) begin
         q_o   = MAX_V[OUT_W-1:0];
         sat_o = 1'b1;
      end else if (shifted_v < MIN_V) begin
         q_o   = MIN_V[OUT_W-1:0];
         sat_o = 1'b1;
      end
   end

endmodule

// File: rtl/result_writeback.sv
// Captures an N x N accumulator matrix (c[i][j] = i_matrix[i][j]), requantises it and drains
// it PACK elements per word through a valid/ready write port, row- or column-major.
module result_writeback
   import sa_pkg::*;
#(
   parameter int N      = SA_N,
   parameter int ACC_W  = SA_ACC_W,
   parameter int OUT_W  = SA_OUT_W,
   parameter int PACK   = SA_PACK,
   parameter int ADDR_W = SA_ADDR_W
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [N-1:0][N-1:0][ACC_W-1:0] i_matrix,
   input  logic [SHIFT_W-1:0]            i_shift,
   input  logic                          i_transpose,
   input  logic [ADDR_W-1:0]             i_base_addr,
   output logic                          o_wr_en,
   input  logic                          i_wr_ready,
   output logic [ADDR_W-1:0]             o_wr_addr,
   output logic [OUT_W*PACK-1:0]         o_wr_data,
   output logic                          o_busy,
   output logic                          o_done,
   output logic [SAT_CNT_W-1:0]          o_sat_count
);

   localparam int WORD_W     = OUT_W * PACK;
   localparam int NUM_WORDS  = (N * N) / PACK;
   localparam int IDX_W      = clog2_min1(NUM_WORDS);
   localparam int LANE_SAT_W = clog2_min1(PACK + 1);

   if ((N * N) % PACK != 0) begin : g_pack_check
      $error("result_writeback: N*N must be divisible by PACK");
   end

   // Buffer holds elements already in drain order, so transpose costs nothing during the drain.
   typedef logic [NUM_WORDS-1:0][PACK-1:0][ACC_W-1:0] drain_buf_t;

   wb_state_e             state_q, state_d;
   drain_buf_t            buf_q, buf_d;
   logic [SHIFT_W-1:0]    shift_q, shift_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [SAT_CNT_W-1:0]  sat_q, sat_d;

   logic [WORD_W-1:0]     word_data;
   logic [PACK-1:0]       lane_sat;
   logic [LANE_SAT_W-1:0] word_sat;
   logic [SAT_CNT_W:0]    sat_sum;
   logic                  last_word;

   for (genvar k = 0; k < PACK; k++) begin : g_lane
      requant_sat #(
         .ACC_W (ACC_W),
         .OUT_W (OUT_W)
      ) u_requant (
         .acc_i   (buf_q[idx_q][k]),
         .shift_i (shift_q),
         .q_o     (word_data[k*OUT_W +: OUT_W]),
         .sat_o   (lane_sat[k])
      );
   end

   always_comb begin
      word_sat = '0;
      for (int k = 0; k < PACK; k++) begin
         word_sat = word_sat + LANE_SAT_W'(lane_sat[k]);
      end
   end

   assign last_word = (idx_q == IDX_W'(NUM_WORDS - 1));
   assign sat_sum   = {1'b0, sat_q} + (SAT_CNT_W+1)'(word_sat);

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      shift_d = shift_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      sat_d   = sat_q;

      unique case (state_q)
         WB_IDLE: begin
            if (i_valid) begin
               state_d = WB_DRAIN;
               shift_d = i_shift;
               addr_d  = i_base_addr;
               idx_d   = '0;
               sat_d   = '0;
               for (int i = 0; i < N; i++) begin
                  for (int j = 0; j < N; j++) begin
                     buf_d[(i*N + j) / PACK][(i*N + j) % PACK] =
                        i_transpose ? i_matrix[j][i] : i_matrix[i][j];
                  end
               end
            end
         end
         WB_DRAIN: begin
            if (i_wr_ready) begin
               sat_d = sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
               if (last_word) begin
                  state_d = WB_DONE;
               end else begin
                  idx_d  = idx_q + 1'b1;
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         WB_DONE: state_d = WB_IDLE;
         default: state_d = WB_IDLE;
      endcase
   end

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= WB_IDLE;
         shift_q <= '0;
         addr_q  <= '0;
         idx_q   <= '0;
         sat_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         sat_q   <= sat_d;
      end
   end

   // NOTE: the matrix buffer has no reset; it is always loaded at capture before it is read,
   // and the write data is gated off outside DRAIN.
   always_ff @(posedge i_clk) begin
      buf_q <= buf_d;
   end

   assign o_ready     = (state_q == WB_IDLE);
   assign o_wr_en     = (state_q == WB_DRAIN);
   assign o_busy      = (state_q != WB_IDLE);
   assign o_done      = (state_q == WB_DONE);
   assign o_wr_addr   = addr_q;
   assign o_wr_data   = (state_q == WB_DRAIN) ? word_data : '0;
   assign o_sat_count = sat_q;

endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: a behavioural model queues expected words and
// completion counts at capture; a negedge monitor compares them against the write port.
`timescale 1ns/1ps
module tb_result_writeback;

   localparam int N         = 4;
   localparam int ACC_W     = 16;
   localparam int OUT_W     = 8;
   localparam int PACK      = 4;
   localparam int ADDR_W    = 4;
   localparam int WORD_W    = OUT_W * PACK;
   localparam int NUM_WORDS = N * N / PACK;

   typedef logic [N-1:0][N-1:0][ACC_W-1:0] mat_t;
   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } wr_exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_valid;
   logic              o_ready;
   mat_t              i_matrix;
   logic [4:0]        i_shift;
   logic              i_transpose;
   logic [ADDR_W-1:0] i_base_addr;
   logic              o_wr_en;
   logic              i_wr_ready;
   logic [ADDR_W-1:0] o_wr_addr;
   logic [WORD_W-1:0] o_wr_data;
   logic              o_busy;
   logic              o_done;
   logic [15:0]       o_sat_count;

   result_writeback #(
      .N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .PACK(PACK), .ADDR_W(ADDR_W)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_matrix    (i_matrix),
      .i_shift     (i_shift),
      .i_transpose (i_transpose),
      .i_base_addr (i_base_addr),
      .o_wr_en     (o_wr_en),
      .i_wr_ready  (i_wr_ready),
      .o_wr_addr   (o_wr_addr),
      .o_wr_data   (o_wr_data),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_sat_count (o_sat_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_accept = 0;
   int cap_edge = 0;

   wr_exp_t exp_q[$];
   int      done_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference requantiser: floor((x + 2^(s-1)) / 2^s), then clamp to the OUT_W range.
   function automatic logic [OUT_W-1:0] requant_ref(input logic [ACC_W-1:0] raw, input int shift,
                                                    output bit clamped);
      longint x, num, den, y, lo, hi;
      int     s;
      x = longint'(signed'(raw));
      s = (shift >= ACC_W) ? ACC_W - 1 : shift;
      if (s == 0) begin
         y = x;
      end else begin
         den = longint'(2) ** s;
         num = x + den / 2;
         y   = num / den;
         if ((num % den != 0) && (num < 0)) y = y - 1;
      end
      hi = longint'(2) ** (OUT_W - 1) - 1;
      lo = -(longint'(2) ** (OUT_W - 1));
      clamped = (y > hi) || (y < lo);
      if (y > hi) y = hi;
      if (y < lo) y = lo;
      return OUT_W'(y);
   endfunction

   function automatic logic [ACC_W-1:0] elem(input mat_t m, input bit tr, input int e);
      return tr ? m[e % N][e / N] : m[e / N][e % N];
   endfunction

   task automatic push_expected(input mat_t m, input int shift, input bit tr,
                                input logic [ADDR_W-1:0] base);
      int sats = 0;
      for (int w = 0; w < NUM_WORDS; w++) begin
         wr_exp_t ex;
         bit      c;
         ex.addr = ADDR_W'((int'(base) + w) % (1 << ADDR_W));
         ex.data = '0;
         for (int k = 0; k < PACK; k++) begin
            ex.data[k*OUT_W +: OUT_W] = requant_ref(elem(m, tr, w*PACK + k), shift, c);
            sats += int'(c);
         end
         exp_q.push_back(ex);
      end
      done_q.push_back((sats > 65535) ? 65535 : sats);
   endtask

   // Monitor: compares every accepted word and every completion pulse against the queues.
   logic              hold_pend = 1'b0;
   logic [ADDR_W-1:0] hold_addr = '0;
   logic [WORD_W-1:0] hold_data = '0;

   always @(negedge clk) begin
      if (rst) begin
         hold_pend <= 1'b0;
      end else begin
         if (hold_pend) begin
            check("hold_wr_en", o_wr_en, 1'b1);
            check("hold_wr_addr", o_wr_addr, hold_addr);
            check("hold_wr_data", o_wr_data, hold_data);
         end
         hold_pend <= o_wr_en && !i_wr_ready;
         hold_addr <= o_wr_addr;
         hold_data <= o_wr_data;
         check("ready_is_not_busy", o_ready, !o_busy);
         if (o_wr_en && i_wr_ready) begin
            n_accept <= n_accept + 1;
            check("write_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               check("wr_addr", o_wr_addr, exp_q[0].addr);
               check("wr_data", o_wr_data, exp_q[0].data);
               void'(exp_q.pop_front());
            end
         end
         if (o_done) begin
            check("done_after_all_words", exp_q.size(), 0);
            check("done_expected", done_q.size() > 0, 1'b1);
            if (done_q.size() > 0) begin
               check("sat_count", o_sat_count, done_q[0]);
               void'(done_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic mat_t rand_mat();
      mat_t m;
      int   mode = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            case (mode)
               0:       m[i][j] = ACC_W'($urandom);
               1:       m[i][j] = ACC_W'(int'($urandom_range(0, 400)) - 200);
               default: m[i][j] = ACC_W'(int'($urandom_range(0, 4000)) - 2000);
            endcase
         end
      end
      return m;
   endfunction

   task automatic scramble();
      i_matrix    = rand_mat();
      i_shift     = 5'($urandom);
      i_transpose = 1'($urandom);
      i_base_addr = ADDR_W'($urandom);
   endtask

   task automatic send(input mat_t m, input int shift, input bit tr, input logic [ADDR_W-1:0] base);
      check("ready_before_capture", o_ready, 1'b1);
      push_expected(m, shift, tr, base);
      i_valid     = 1'b1;
      i_matrix    = m;
      i_shift     = 5'(shift);
      i_transpose = tr;
      i_base_addr = base;
      tick();
      cap_edge = cyc;
      i_valid  = 1'b0;
      scramble();
      check("wr_en_after_capture", o_wr_en, 1'b1);
   endtask

   task automatic drain(input bit rand_ready, input bit noise, output int done_off);
      done_off = -1;
      for (int i = 0; i < 300; i++) begin
         if (o_done) begin
            done_off = cyc - cap_edge;
            break;
         end
         i_wr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (noise) begin
            i_valid = 1'($urandom);
            scramble();
         end
         tick();
      end
      i_valid = 1'b0;
      check("done_seen", done_off >= 0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      mat_t              m;
      int                off;
      int                acc0;
      logic [ADDR_W-1:0] wrap_addr[4];

      rst = 1'b1; i_valid = 1'b0; i_wr_ready = 1'b1;
      i_matrix = '0; i_shift = '0; i_transpose = 1'b0; i_base_addr = '0;
      tick();
      tick();
      check("rst_ready", o_ready, 1'b1);
      check("rst_wr_en", o_wr_en, 1'b0);
      check("rst_wr_addr", o_wr_addr, 0);
      check("rst_wr_data", o_wr_data, 0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_done", o_done, 1'b0);
      check("rst_sat_count", o_sat_count, 0);
      rst = 1'b0;
      tick();

      // Ramp matrix, row-major then column-major.
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            m[i][j] = ACC_W'(4*i + j);
      send(m, 0, 1'b0, '0);
      check("ramp_word0", o_wr_data, 32'h03020100);
      check("ramp_addr0", o_wr_addr, 0);
      drain(1'b0, 1'b0, off);
      check("ramp_done_latency", off, NUM_WORDS);
      tick();
      check("done_one_cycle", o_done, 1'b0);
      check("ready_after_done", o_ready, 1'b1);

      send(m, 0, 1'b1, '0);
      check("transpose_word0", o_wr_data, 32'h0C080400);
      drain(1'b0, 1'b0, off);
      tick();

      // Saturation at shift 0.
      m = '0;
      m[0][0] = 16'd200;
      m[0][1] = 16'hFED4;
      send(m, 0, 1'b0, '0);
      check("sat_word0", o_wr_data, 32'h0000807F);
      drain(1'b0, 1'b0, off);
      check("sat_count_two", o_sat_count, 2);
      tick(); tick(); tick();
      check("sat_count_held", o_sat_count, 2);

      // Rounding at shift 2.
      m = '0;
      m[0][0] = 16'd5;
      m[0][1] = 16'd6;
      m[0][2] = 16'hFFFA;
      m[0][3] = 16'hFFF9;
      send(m, 2, 1'b0, '0);
      check("round_word0", o_wr_data, 32'hFEFF0201);
      drain(1'b0, 1'b0, off);
      tick();

      // Back-pressure on word 1.
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            m[i][j] = ACC_W'(4*i + j);
      acc0 = n_accept;
      send(m, 0, 1'b0, '0);
      tick();
      i_wr_ready = 1'b0;
      tick(); tick(); tick();
      drain(1'b0, 1'b0, off);
      check("stall_done_latency", off, NUM_WORDS + 3);
      check("stall_accept_count", n_accept - acc0, NUM_WORDS);
      tick();

      // Address wrap with a 4-bit address.
      wrap_addr[0] = 4'd14; wrap_addr[1] = 4'd15; wrap_addr[2] = 4'd0; wrap_addr[3] = 4'd1;
      send(rand_mat(), 1, 1'b0, 4'd14);
      for (int w = 0; w < NUM_WORDS; w++) begin
         check("wrap_addr", o_wr_addr, wrap_addr[w]);
         tick();
      end
      drain(1'b0, 1'b0, off);
      check("wrap_done_latency", off, NUM_WORDS);
      tick();

      // Reset after two accepted words, with a simultaneous i_valid.
      send(rand_mat(), 3, 1'b0, 4'd5);
      tick();
      tick();
      rst = 1'b1;
      i_valid = 1'b1;
      i_wr_ready = 1'b0;
      exp_q.delete();
      done_q.delete();
      tick();
      check("abort_wr_en", o_wr_en, 1'b0);
      check("abort_ready", o_ready, 1'b1);
      check("abort_busy", o_busy, 1'b0);
      check("abort_done", o_done, 1'b0);
      rst = 1'b0;
      i_valid = 1'b0;
      i_wr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_no_done", o_done, 1'b0);
      end
      send(rand_mat(), 4, 1'b1, 4'd9);
      drain(1'b0, 1'b0, off);
      check("post_abort_latency", off, NUM_WORDS);
      tick();

      // Randomised traffic with back-pressure and ignored i_valid noise during the drain.
      for (int t = 0; t < 24; t++) begin
         int idle = $urandom_range(0, 3);
         for (int c = 0; c < idle; c++) begin
            i_wr_ready = 1'($urandom);
            tick();
         end
         send(rand_mat(), $urandom_range(0, 31), 1'($urandom), ADDR_W'($urandom));
         drain(1'b1, 1'b1, off);
         tick();
      end

      tick();
      check("scoreboard_empty", exp_q.size(), 0);
      check("done_queue_empty", done_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
